// File: rtl/frame_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frame_capture_writer
//  Purpose  : Camera-side writer for the frame buffer. Pairs RGB444 bytes from
//             the camera byte stream into 16-bit pixels and writes them at
//             consecutive addresses 0..PIXELS-1, then pulses frame_done with
//             the number of pixels written once the frame ends.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PIXELS          pixels per frame; write address range 0..PIXELS-1
//    ADDR_W          width of frame_waddr / frame_pixels
//  Ports
//    clk25           in   system clock, all logic on the rising edge
//    rst             in   asynchronous active-high reset
//    cam_vsync       in   camera vsync (synchronised), high = vertical blank
//    cam_href        in   camera href (synchronised), high = active line bytes
//    cam_byte_valid  in   one-cycle strobe, cam_data holds a new byte
//    cam_data        in   camera byte: 1st = xxxxRRRR, 2nd = GGGGBBBB
//    frame_we        out  buffer write enable, one cycle per pixel
//    frame_waddr     out  buffer write address
//    frame_wdata     out  pixel {4'b0, R, G, B}; red sits in bits [11:8]
//    frame_done      out  one-cycle pulse after a captured frame has ended
//    frame_pixels    out  pixels written in the last completed frame
//    overflow        out  sticky per frame: more than PIXELS pixels arrived
// ============================================================================
module frame_capture_writer #(
  parameter int PIXELS = 76800,
  parameter int ADDR_W = 17
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_valid,
  input  logic [7:0]        cam_data,
  output logic              frame_we,
  output logic [ADDR_W-1:0] frame_waddr,
  output logic [15:0]       frame_wdata,
  output logic              frame_done,
  output logic [ADDR_W-1:0] frame_pixels,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] c_pixels = ADDR_W'(PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // after reset: wait for a clean frame start
    ST_SYNC    = 2'd1,  // vertical blank
    ST_CAPTURE = 2'd2   // active frame, bytes are turned into pixels
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_vsync_prev;
  logic              r_phase;       // 0: expecting R byte, 1: expecting GB byte
  logic [3:0]        r_red;
  logic [ADDR_W-1:0] r_addr;        // next write address == writes so far

  logic              r_frame_we;
  logic [ADDR_W-1:0] r_frame_waddr;
  logic [15:0]       r_frame_wdata;
  logic              r_frame_done;
  logic [ADDR_W-1:0] r_frame_pixels;
  logic              r_overflow;

  logic              w_vsync_rise;
  logic              w_vsync_fall;
  logic              w_capture_start;
  logic              w_accept;
  logic              w_pixel_done;
  logic              w_write;
  logic              w_frame_end;
  logic [15:0]       w_pixel;

  // Edge detection against a one-cycle delayed copy of vsync.
  assign w_vsync_rise = cam_vsync & ~r_vsync_prev;
  assign w_vsync_fall = ~cam_vsync & r_vsync_prev;

  assign w_pixel = {4'b0000, r_red, cam_data};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-cycle control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_capture_start = 1'b0;
    w_accept        = 1'b0;
    w_pixel_done    = 1'b0;
    w_write         = 1'b0;
    w_frame_end     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A frame already in progress at reset is never written; wait for
        // the next blank to begin.
        if (w_vsync_rise) begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (w_vsync_fall) begin
          w_state_nxt     = ST_CAPTURE;
          w_capture_start = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_accept     = cam_href & cam_byte_valid;
        w_pixel_done = w_accept & r_phase;
        // Pixels beyond the buffer are dropped rather than wrapped.
        w_write      = w_pixel_done & (r_addr < c_pixels);
        if (w_vsync_rise) begin
          w_state_nxt = ST_SYNC;
          w_frame_end = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: byte pairing, address counter, write port and frame status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_vsync_prev   <= 1'b0;
      r_phase        <= 1'b0;
      r_red          <= 4'h0;
      r_addr         <= '0;
      r_frame_we     <= 1'b0;
      r_frame_waddr  <= '0;
      r_frame_wdata  <= 16'h0000;
      r_frame_done   <= 1'b0;
      r_frame_pixels <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_vsync_prev <= cam_vsync;
      r_frame_we   <= w_write;
      r_frame_done <= w_frame_end;

      if (w_write) begin
        r_frame_waddr <= r_addr;
        r_frame_wdata <= w_pixel;
      end

      // A pixel completing in the same cycle as the vsync rise is still
      // written, so it is included in the reported count.
      if (w_frame_end) begin
        r_frame_pixels <= r_addr + (w_write ? ADDR_W'(1) : ADDR_W'(0));
      end

      if (w_capture_start) begin
        r_addr     <= '0;
        r_phase    <= 1'b0;
        r_overflow <= 1'b0;
      end else if (r_state == ST_CAPTURE) begin
        if (!cam_href) begin
          // Line gap: a dangling odd byte is discarded.
          r_phase <= 1'b0;
        end else if (w_accept) begin
          if (!r_phase) begin
            r_red   <= cam_data[3:0];
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_write) begin
              r_addr <= r_addr + ADDR_W'(1);
            end else begin
              // Buffer full: address holds, flag stays until next frame.
              r_overflow <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign frame_we     = r_frame_we;
  assign frame_waddr  = r_frame_waddr;
  assign frame_wdata  = r_frame_wdata;
  assign frame_done   = r_frame_done;
  assign frame_pixels = r_frame_pixels;
  assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_frame_capture_writer
//  Purpose  : Self-checking bench for frame_capture_writer. The frame size is
//             scaled down (4 lines x 24 bytes = 48 pixels) so full frames,
//             overflow and restart after reset all fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_capture_writer;

  localparam int PIX        = 48;
  localparam int AW         = 17;
  localparam int LINES      = 4;
  localparam int LINE_BYTES = 24;

  logic          clk25 = 1'b0;
  logic          rst = 1'b1;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic          cam_byte_valid = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          frame_we;
  logic [AW-1:0] frame_waddr;
  logic [15:0]   frame_wdata;
  logic          frame_done;
  logic [AW-1:0] frame_pixels;
  logic          overflow;

  frame_capture_writer #(
    .PIXELS(PIX),
    .ADDR_W(AW)
  ) dut (
    .clk25         (clk25),
    .rst           (rst),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_byte_valid(cam_byte_valid),
    .cam_data      (cam_data),
    .frame_we      (frame_we),
    .frame_waddr   (frame_waddr),
    .frame_wdata   (frame_wdata),
    .frame_done    (frame_done),
    .frame_pixels  (frame_pixels),
    .overflow      (overflow)
  );

  always #5 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; int cnt; } done_t;

  wr_t         exp_wr[$];
  done_t       exp_done[$];
  logic [7:0]  line_q[$];
  int          wq_addr[$];          // every address the DUT wrote, in order
  logic [15:0] log_data [0:PIX-1];  // last data written per address

  bit m_cap  = 1'b0;   // a frame is being captured
  bit m_rose = 1'b0;   // vsync rose since reset / last capture start
  int m_cnt  = 0;      // pixels written in the current frame
  bit m_ovf  = 1'b0;

  task automatic model_pixel(input logic [7:0] rb, input logic [7:0] gb);
    if (m_cnt < PIX) begin
      exp_wr.push_back('{cyc + 1, m_cnt, {4'h0, rb[3:0], gb}});
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_rise();
    if (m_cap) exp_done.push_back('{cyc + 1, m_cnt});
    m_cap  = 1'b0;
    m_rose = 1'b1;
  endtask

  // ---------------- compare process ----------------
  task automatic compare_loop();
    forever begin
      @(negedge clk25);
      if (!rst) begin
        while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL write_missing: no write seen, expected addr %0d at cycle %0d",
                   exp_wr[0].addr, exp_wr[0].cyc);
          void'(exp_wr.pop_front());
        end
        if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
          chk("frame_we", frame_we, 1);
          chk("frame_waddr", frame_waddr, exp_wr[0].addr);
          chk("frame_wdata", frame_wdata, exp_wr[0].data);
          void'(exp_wr.pop_front());
        end else begin
          chk("frame_we_idle", frame_we, 0);
        end
        while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL done_missing: no frame_done, expected count %0d at cycle %0d",
                   exp_done[0].cnt, exp_done[0].cyc);
          void'(exp_done.pop_front());
        end
        if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
          chk("frame_done", frame_done, 1);
          chk("frame_pixels", frame_pixels, exp_done[0].cnt);
          void'(exp_done.pop_front());
        end else begin
          chk("frame_done_idle", frame_done, 0);
        end
        if (frame_we === 1'b1) begin
          wq_addr.push_back(int'(frame_waddr));
          if (int'(frame_waddr) < PIX) log_data[frame_waddr] = frame_wdata;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic fill_line(input int base, input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(8'(base + i * 37));
  endtask

  task automatic send_line(input bit gaps, input bit rise_on_last, input bit keep_href);
    int n;
    n = line_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk25); #1;
      cam_href       = 1'b1;
      cam_byte_valid = 1'b1;
      cam_data       = line_q[i];
      if (rise_on_last && i == n - 1) cam_vsync = 1'b1;
      if (m_cap && (i % 2 == 1)) model_pixel(line_q[i-1], line_q[i]);
      if (rise_on_last && i == n - 1) model_rise();
      if (gaps && (i % 3 == 2) && i != n - 1) begin
        @(posedge clk25); #1;
        cam_byte_valid = 1'b0;
      end
    end
    if (!keep_href) begin
      @(posedge clk25); #1;
      cam_href       = 1'b0;
      cam_byte_valid = 1'b0;
      @(posedge clk25); #1;
    end
  endtask

  task automatic vsync_rise();
    @(posedge clk25); #1;
    cam_vsync = 1'b1;
    model_rise();
    repeat (3) @(posedge clk25);
    #1;
  endtask

  task automatic vsync_fall();
    @(posedge clk25); #1;
    cam_vsync = 1'b0;
    if (m_rose) begin
      m_cap  = 1'b1;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_rose = 1'b0;
    end
    repeat (3) @(posedge clk25);
    #1;
  endtask

  task automatic full_frame(input int base);
    for (int l = 0; l < LINES; l++) begin
      fill_line(base + l, LINE_BYTES);
      send_line(l == 1, 1'b0, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    fork
      compare_loop();
    join_none

    // Reset values
    repeat (3) @(posedge clk25);
    #1;
    chk("rst_frame_we", frame_we, 0);
    chk("rst_frame_waddr", frame_waddr, 0);
    chk("rst_frame_wdata", frame_wdata, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_pixels", frame_pixels, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Bytes before any vsync rise, then bytes during blank: all discarded
    fill_line(8'h11, 8);
    send_line(1'b0, 1'b0, 1'b0);
    vsync_rise();
    fill_line(8'h22, 6);
    send_line(1'b0, 1'b0, 1'b0);
    vsync_fall();
    chk("no_write_before_capture", wq_addr.size(), 0);

    // Single short line, then end of frame
    line_q = '{8'h0A, 8'h5C, 8'h03, 8'hF1};
    send_line(1'b0, 1'b0, 1'b0);
    vsync_rise();
    chk("short_pix0", log_data[0], 16'h0A5C);
    chk("short_pix1", log_data[1], 16'h03F1);
    chk("short_count", frame_pixels, 2);

    // Full frame
    vsync_fall();
    chk("full_ovf_cleared", overflow, 0);
    full_frame(8'h40);
    vsync_rise();
    chk("full_count", frame_pixels, PIX);
    chk("full_overflow", overflow, 0);
    chk("full_last_addr", wq_addr[wq_addr.size()-1], PIX - 1);
    chk("full_total_writes", wq_addr.size(), 2 + PIX);

    // Odd-length line is realigned; last pixel coincides with vsync rise
    vsync_fall();
    line_q.delete();
    for (int i = 0; i < 25; i++) line_q.push_back(8'hE7);
    send_line(1'b0, 1'b0, 1'b0);
    line_q.delete();
    for (int i = 0; i < 24; i++) line_q.push_back(8'(8'h3C + i));
    send_line(1'b0, 1'b1, 1'b0);
    chk("odd_last_pix_line1", log_data[11], 16'h07E7);
    chk("odd_first_pix_line2", log_data[12], 16'h0C3D);
    chk("odd_count", frame_pixels, 24);

    // One pixel too many
    vsync_fall();
    full_frame(8'h80);
    line_q = '{8'h0B, 8'hCD};
    send_line(1'b0, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_model", overflow, m_ovf);
    chk("ovf_buffer_end", log_data[PIX-1], exp_last_pixel(8'h80 + LINES - 1));
    vsync_rise();
    chk("ovf_count", frame_pixels, PIX);
    chk("ovf_held", overflow, 1);
    vsync_fall();
    chk("ovf_cleared", overflow, 0);

    // Reset in the middle of a line
    fill_line(8'h60, LINE_BYTES);
    send_line(1'b0, 1'b0, 1'b0);
    fill_line(8'h61, 10);
    send_line(1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    exp_wr.delete();
    exp_done.delete();
    m_cap = 1'b0; m_rose = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    cam_href = 1'b0; cam_byte_valid = 1'b0;
    #1;
    chk("midrst_frame_we", frame_we, 0);
    chk("midrst_frame_waddr", frame_waddr, 0);
    chk("midrst_frame_wdata", frame_wdata, 0);
    chk("midrst_frame_pixels", frame_pixels, 0);
    chk("midrst_overflow", overflow, 0);
    repeat (2) @(posedge clk25);
    #1;
    rst = 1'b0;
    fill_line(8'h55, 8);
    send_line(1'b0, 1'b0, 1'b0);
    base = wq_addr.size();
    vsync_rise();
    vsync_fall();
    full_frame(8'hC0);
    vsync_rise();
    chk("restart_first_addr", (wq_addr.size() > base) ? wq_addr[base] : -1, 0);
    chk("restart_writes", wq_addr.size() - base, PIX);
    chk("restart_count", frame_pixels, PIX);

    repeat (4) @(posedge clk25);
    #1;
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_done", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Pixel formed from the last two bytes of a line built by fill_line.
  function automatic logic [15:0] exp_last_pixel(input int base);
    logic [7:0] rb;
    logic [7:0] gb;
    rb = 8'(base + (LINE_BYTES - 2) * 37);
    gb = 8'(base + (LINE_BYTES - 1) * 37);
    return {4'h0, rb[3:0], gb};
  endfunction

endmodule
`default_nettype wire
